// File: rtl/pio_event_pkg.sv
// Shared types and constants for the PIO event servicer.
//   state_e       : servicer FSM states
//   ADDR_*        : PIO s1 register addresses
//   evt_*_lsb()   : bit offsets of the fields in an event record
//                   {edges, level, timestamp}, edges in the MSBs
package pio_event_pkg;

  typedef enum logic [2:0] {
    MASK_WR  = 3'd0,
    IDLE     = 3'd1,
    RD_EDGE  = 3'd2,
    CLR_EDGE = 3'd3,
    RD_LVL   = 3'd4,
    PUSH     = 3'd5
  } state_e;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  function automatic int evt_ts_lsb();
    return 0;
  endfunction

  function automatic int evt_lvl_lsb(input int ts_w);
    return ts_w;
  endfunction

  function automatic int evt_edge_lsb(input int data_w, input int ts_w);
    return ts_w + data_w;
  endfunction

  function automatic int evt_width(input int data_w, input int ts_w);
    return 2 * data_w + ts_w;
  endfunction

endpackage

// File: rtl/pio_event_servicer_if.sv
// Avalon-MM bus between the event servicer (master) and the PIO s1 slave.
//   pio_address    : register address (master -> slave)
//   pio_chipselect : asserted on writes only
//   pio_write_n    : active-low write strobe
//   pio_writedata  : write data
//   pio_readdata   : registered read data, 1 cycle after address
//   pio_irq        : level interrupt from the PIO
interface pio_event_servicer_if;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic        pio_irq;

  modport master (
    output pio_address, pio_chipselect, pio_write_n, pio_writedata,
    input  pio_readdata, pio_irq
  );

  modport slave (
    input  pio_address, pio_chipselect, pio_write_n, pio_writedata,
    output pio_readdata, pio_irq
  );
endinterface

// File: rtl/pio_event_fifo.sv
// Synchronous FIFO holding event records, with a registered head word.
//   clk, reset : clock, asynchronous active-high reset (flushes contents)
//   push/wdata : write a record; ignored when full
//   pop        : consume head; ignored when empty
//   rdata      : registered head record, valid while !empty
//   full/empty : occupancy flags
//   count      : occupancy, 0..DEPTH
module pio_event_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    rd_nxt_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_nxt_s;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty_s   = (count_r == {CW{1'b0}});
  assign push_ok_s = push && !full_s;
  assign pop_ok_s  = pop && !empty_s;
  assign rd_nxt_s  = rd_ptr_r + 1'b1;

  // Next head word: the head is kept in its own register so evt_data is a
  // flop output; a record written into an empty (or emptying) FIFO goes
  // straight to the head.
  always_comb begin
    head_nxt_s = head_r;
    if (pop_ok_s) begin
      if (count_r == CW'(1)) begin
        if (push_ok_s) begin
          head_nxt_s = wdata;
        end else begin
          head_nxt_s = head_r;
        end
      end else begin
        head_nxt_s = mem_r[rd_nxt_s];
      end
    end else if (empty_s && push_ok_s) begin
      head_nxt_s = wdata;
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Record storage; contents are don't-care until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      head_r   <= {WIDTH{1'b0}};
    end else begin
      head_r <= head_nxt_s;
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_nxt_s;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = head_r;
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

endmodule

// File: rtl/pio_event_servicer.sv
// Services a 4-bit edge-capture PIO without CPU help: on irq it reads and
// clears the edge-capture register, reads the live level and queues a
// timestamped {edges, level, timestamp} record. Also writes the PIO irq mask
// after reset and whenever cfg_mask_wr requests it.
//   clk, reset  : clock, asynchronous active-high reset
//   pio         : Avalon-MM master port to the PIO s1 slave
//   cfg_mask    : new irq mask, captured on cfg_mask_wr
//   cfg_mask_wr : one-cycle mask write request, serviced at the next IDLE
//   evt_valid   : event FIFO not empty
//   evt_data    : head record {edges, level, timestamp}
//   evt_pop     : consume head record
//   evt_count   : FIFO occupancy
//   busy        : FSM not in IDLE
module pio_event_servicer
  import pio_event_pkg::*;
#(
  parameter int              DATA_W     = 4,
  parameter int              FIFO_DEPTH = 8,
  parameter int              TS_W       = 16,
  parameter logic [DATA_W-1:0] MASK_INIT  = 4'hF
) (
  input  logic                                clk,
  input  logic                                reset,
  pio_event_servicer_if.master                pio,
  input  logic [DATA_W-1:0]                   cfg_mask,
  input  logic                                cfg_mask_wr,
  output logic                                evt_valid,
  output logic [2*DATA_W+TS_W-1:0]            evt_data,
  input  logic                                evt_pop,
  output logic [$clog2(FIFO_DEPTH):0]         evt_count,
  output logic                                busy
);

  localparam int EVT_W    = evt_width(DATA_W, TS_W);
  localparam int TS_LSB   = evt_ts_lsb();
  localparam int LVL_LSB  = evt_lvl_lsb(TS_W);
  localparam int EDGE_LSB = evt_edge_lsb(DATA_W, TS_W);

  state_e            state_r;
  logic [TS_W-1:0]   ts_cnt_r;
  logic [TS_W-1:0]   ts_r;
  logic [DATA_W-1:0] edge_r;
  logic              pend_r;
  logic [DATA_W-1:0] pend_mask_r;
  logic              init_wr_r;
  logic [1:0]        addr_r;
  logic              cs_r;
  logic              wr_n_r;
  logic [31:0]       wdata_r;
  logic              busy_r;
  logic [EVT_W-1:0]  evt_wdata_s;
  logic              evt_push_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              unused_rd_s;

  assign unused_rd_s = ^pio.pio_readdata[31:DATA_W];

  // Free-running timestamp, wraps modulo 2^TS_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt_r <= {TS_W{1'b0}};
    end else begin
      ts_cnt_r <= ts_cnt_r + 1'b1;
    end
  end

  // Record assembly: level comes straight from the read data returned in
  // PUSH, so the push and the level sample happen on the same edge.
  always_comb begin
    evt_wdata_s = {EVT_W{1'b0}};
    evt_wdata_s[EDGE_LSB +: DATA_W] = edge_r;
    evt_wdata_s[LVL_LSB  +: DATA_W] = pio.pio_readdata[DATA_W-1:0];
    evt_wdata_s[TS_LSB   +: TS_W]   = ts_r;
  end

  // A spurious irq with no captured edge produces no record.
  assign evt_push_s = (state_r == PUSH) && (edge_r != {DATA_W{1'b0}});

  // Servicer FSM with registered bus outputs; outputs are loaded on the
  // transition into the state that presents them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= MASK_WR;
      init_wr_r   <= 1'b1;
      pend_r      <= 1'b0;
      pend_mask_r <= {DATA_W{1'b0}};
      ts_r        <= {TS_W{1'b0}};
      edge_r      <= {DATA_W{1'b0}};
      addr_r      <= ADDR_DATA;
      cs_r        <= 1'b0;
      wr_n_r      <= 1'b1;
      wdata_r     <= 32'h0000_0000;
      busy_r      <= 1'b1;
    end else begin
      case (state_r)
        MASK_WR: begin
          if (init_wr_r) begin
            // First cycle after reset: the bus is still quiet, so issue
            // the MASK_INIT write now and stay for its one cycle.
            init_wr_r <= 1'b0;
            addr_r    <= ADDR_MASK;
            cs_r      <= 1'b1;
            wr_n_r    <= 1'b0;
            wdata_r   <= {{(32-DATA_W){1'b0}}, MASK_INIT};
          end else begin
            state_r <= IDLE;
            addr_r  <= ADDR_EDGE;
            cs_r    <= 1'b0;
            wr_n_r  <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        IDLE: begin
          if (pend_r) begin
            state_r <= MASK_WR;
            pend_r  <= 1'b0;
            addr_r  <= ADDR_MASK;
            cs_r    <= 1'b1;
            wr_n_r  <= 1'b0;
            wdata_r <= {{(32-DATA_W){1'b0}}, pend_mask_r};
            busy_r  <= 1'b1;
          end else if (pio.pio_irq && !fifo_full_s) begin
            state_r <= RD_EDGE;
            addr_r  <= ADDR_EDGE;
            busy_r  <= 1'b1;
          end else begin
            addr_r <= ADDR_EDGE;
            cs_r   <= 1'b0;
            wr_n_r <= 1'b1;
          end
        end
        RD_EDGE: begin
          ts_r    <= ts_cnt_r;
          state_r <= CLR_EDGE;
          addr_r  <= ADDR_EDGE;
          cs_r    <= 1'b1;
          wr_n_r  <= 1'b0;
          wdata_r <= 32'hFFFF_FFFF;
        end
        CLR_EDGE: begin
          // Read data here answers the address held during RD_EDGE, i.e.
          // the edge register before this cycle's clear lands.
          edge_r  <= pio.pio_readdata[DATA_W-1:0];
          state_r <= RD_LVL;
          addr_r  <= ADDR_DATA;
          cs_r    <= 1'b0;
          wr_n_r  <= 1'b1;
        end
        RD_LVL: begin
          state_r <= PUSH;
          addr_r  <= ADDR_DATA;
        end
        PUSH: begin
          state_r <= IDLE;
          addr_r  <= ADDR_EDGE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r   <= MASK_WR;
          init_wr_r <= 1'b1;
          addr_r    <= ADDR_DATA;
          cs_r      <= 1'b0;
          wr_n_r    <= 1'b1;
          busy_r    <= 1'b1;
        end
      endcase
      // Placed last so a request arriving in any state, including the
      // IDLE cycle that consumes an older one, is kept; last request wins.
      if (cfg_mask_wr) begin
        pend_r      <= 1'b1;
        pend_mask_r <= cfg_mask;
      end
    end
  end

  pio_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (evt_push_s),
    .wdata (evt_wdata_s),
    .pop   (evt_pop),
    .rdata (evt_data),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (evt_count)
  );

  assign pio.pio_address    = addr_r;
  assign pio.pio_chipselect = cs_r;
  assign pio.pio_write_n    = wr_n_r;
  assign pio.pio_writedata  = wdata_r;
  assign evt_valid          = !fifo_empty_s;
  assign busy               = busy_r;

endmodule

// File: tb/tb_pio_event_servicer.sv
module tb_pio_event_servicer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cfg_mask;
  logic        cfg_mask_wr;
  logic        evt_valid;
  logic [23:0] evt_data;
  logic        evt_pop;
  logic [3:0]  evt_count;
  logic        busy;

  always #5 clk = ~clk;

  pio_event_servicer_if pio ();

  pio_event_servicer dut (
    .clk         (clk),
    .reset       (rst),
    .pio         (pio),
    .cfg_mask    (cfg_mask),
    .cfg_mask_wr (cfg_mask_wr),
    .evt_valid   (evt_valid),
    .evt_data    (evt_data),
    .evt_pop     (evt_pop),
    .evt_count   (evt_count),
    .busy        (busy)
  );

  // ---------------- PIO s1 model: edge capture, irq mask, registered read
  logic [3:0]  in_port;
  logic [3:0]  in_q;
  logic [3:0]  edge_cap;
  logic [3:0]  irq_mask;
  logic [31:0] rd_q;
  logic [3:0]  clr_bits;
  logic        pio_wr;

  assign pio_wr   = pio.pio_chipselect && !pio.pio_write_n;
  assign clr_bits = (pio_wr && pio.pio_address == 2'd3) ? pio.pio_writedata[3:0] : 4'b0000;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q     <= 4'b0000;
      edge_cap <= 4'b0000;
      irq_mask <= 4'b0000;
      rd_q     <= 32'h0;
    end else begin
      in_q     <= in_port;
      edge_cap <= (edge_cap & ~clr_bits) | (in_port & ~in_q);
      if (pio_wr && pio.pio_address == 2'd2) irq_mask <= pio.pio_writedata[3:0];
      case (pio.pio_address)
        2'd0:    rd_q <= {28'h0, in_port};
        2'd2:    rd_q <= {28'h0, irq_mask};
        2'd3:    rd_q <= {28'h0, edge_cap};
        default: rd_q <= 32'h0;
      endcase
    end
  end

  assign pio.pio_readdata = rd_q;
  assign pio.pio_irq      = |(edge_cap & irq_mask);

  // ---------------- cycle counter (mirrors a timestamp started at reset exit)
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- PIO write log
  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t wlog[$];

  always @(posedge clk) begin
    if (!rst && pio_wr) wlog.push_back('{a: pio.pio_address, d: pio.pio_writedata});
  end

  // ---------------- scoreboard and checking
  logic [23:0] sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Rising edge(s) on pat from a quiet input; the record is expected with
  // RD_EDGE two cycles after the drive (capture, then irq seen in IDLE).
  task automatic gen_event(input logic [3:0] pat);
    in_port = 4'b0000;
    tick(2);
    in_port = pat;
    sb.push_back({pat, pat, 16'(cyc + 2)});
  endtask

  task automatic pop_chk(input string tag);
    logic [23:0] exp;
    if (sb.size() > 0) exp = sb.pop_front();
    else               exp = 24'hxxxxxx;
    check_val({tag, "_valid"}, {31'h0, evt_valid}, 32'h1);
    check_val({tag, "_data"}, {8'h0, evt_data}, {8'h0, exp});
    evt_pop = 1'b1;
    tick(1);
    evt_pop = 1'b0;
  endtask

  logic [3:0] fill_pat [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5, 4'h6, 4'h9};

  initial begin
    int p;
    int c;
    int bad;
    rst = 1'b1; in_port = 4'b0000; cfg_mask = 4'b0000; cfg_mask_wr = 1'b0; evt_pop = 1'b0;
    tick(3);
    // Reset values
    check_val("rst_addr",  {30'h0, pio.pio_address}, 32'h0);
    check_val("rst_cs",    {31'h0, pio.pio_chipselect}, 32'h0);
    check_val("rst_wr_n",  {31'h0, pio.pio_write_n}, 32'h1);
    check_val("rst_wdata", pio.pio_writedata, 32'h0);
    check_val("rst_valid", {31'h0, evt_valid}, 32'h0);
    check_val("rst_count", {28'h0, evt_count}, 32'h0);
    check_val("rst_busy",  {31'h0, busy}, 32'h1);

    // Test 1: reset exit writes MASK_INIT once, then idles on address 3
    wlog.delete();
    rst = 1'b0;
    tick(6);
    check_val("init_wr_cnt", 32'(wlog.size()), 32'd1);
    if (wlog.size() > 0) begin
      check_val("init_wr_addr", {30'h0, wlog[0].a}, 32'h2);
      check_val("init_wr_data", wlog[0].d, 32'h0000_000F);
    end
    check_val("init_busy", {31'h0, busy}, 32'h0);
    check_val("init_addr", {30'h0, pio.pio_address}, 32'h3);

    // Test 2: single rising edge on bit 2, latency and irq clear
    wlog.delete();
    gen_event(4'b0100);
    tick(4);
    check_val("ev_irq_low", {31'h0, pio.pio_irq}, 32'h0);
    tick(1);
    check_val("ev_valid_n4", {31'h0, evt_valid}, 32'h0);
    tick(1);
    check_val("ev_valid_n5", {31'h0, evt_valid}, 32'h1);
    check_val("ev_count", {28'h0, evt_count}, 32'h1);
    check_val("ev_wr_cnt", 32'(wlog.size()), 32'd1);
    if (wlog.size() > 0) begin
      check_val("ev_clr_addr", {30'h0, wlog[0].a}, 32'h3);
      check_val("ev_clr_data", wlog[0].d, 32'hFFFF_FFFF);
    end
    pop_chk("ev_pop");
    check_val("ev_count_after", {28'h0, evt_count}, 32'h0);

    // Test 3: fill FIFO, pending edge waits while full
    for (int i = 0; i < 8; i++) begin
      gen_event(fill_pat[i]);
      tick(8);
    end
    check_val("full_count", {28'h0, evt_count}, 32'd8);
    in_port = 4'b0000;
    tick(2);
    in_port = 4'b0001;
    wlog.delete();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (pio.pio_address !== 2'd3 || pio.pio_chipselect !== 1'b0 || busy !== 1'b0) bad++;
    end
    check_val("full_bus_quiet", 32'(bad), 32'd0);
    check_val("full_no_wr", 32'(wlog.size()), 32'd0);
    check_val("full_irq_held", {31'h0, pio.pio_irq}, 32'h1);
    c = cyc;
    pop_chk("full_pop");
    sb.push_back({4'b0001, 4'b0001, 16'(c + 2)});
    check_val("full_count_7", {28'h0, evt_count}, 32'd7);
    tick(4);
    check_val("full_count_7b", {28'h0, evt_count}, 32'd7);
    tick(1);
    check_val("full_count_8", {28'h0, evt_count}, 32'd8);
    for (int i = 0; i < 8; i++) pop_chk("drain");
    check_val("drain_count", {28'h0, evt_count}, 32'd0);

    // Test 5: same-cycle push and pop at count 3
    gen_event(4'b0010); tick(8);
    gen_event(4'b0100); tick(8);
    gen_event(4'b0110); tick(8);
    check_val("pp_count_pre", {28'h0, evt_count}, 32'd3);
    gen_event(4'b0011);
    tick(5);
    check_val("pp_count_push", {28'h0, evt_count}, 32'd3);
    pop_chk("pp_pop");
    check_val("pp_count_same", {28'h0, evt_count}, 32'd3);
    for (int i = 0; i < 3; i++) pop_chk("pp_drain");
    check_val("pp_empty", {31'h0, evt_valid}, 32'h0);
    evt_pop = 1'b1;
    tick(1);
    evt_pop = 1'b0;
    check_val("pop_empty_count", {28'h0, evt_count}, 32'd0);

    // Test 6: reset during RD_LVL with two records queued
    gen_event(4'b0001); tick(8);
    gen_event(4'b0010); tick(8);
    check_val("rr_count_pre", {28'h0, evt_count}, 32'd2);
    gen_event(4'b0100);
    tick(4);
    check_val("rr_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    in_port = 4'b0000;
    tick(1);
    check_val("rr_count", {28'h0, evt_count}, 32'd0);
    check_val("rr_valid", {31'h0, evt_valid}, 32'h0);
    check_val("rr_busy_rst", {31'h0, busy}, 32'h1);
    sb.delete();
    wlog.delete();
    rst = 1'b0;
    tick(6);
    check_val("rr_wr_cnt", 32'(wlog.size()), 32'd1);
    if (wlog.size() > 0) begin
      check_val("rr_wr_addr", {30'h0, wlog[0].a}, 32'h2);
      check_val("rr_wr_data", wlog[0].d, 32'h0000_000F);
    end
    check_val("rr_count_post", {28'h0, evt_count}, 32'd0);

    // Test 4: mask request during CLR_EDGE is serviced after the event
    wlog.delete();
    gen_event(4'b0010);
    p = cyc;
    tick(3);
    check_val("mk_in_clr", {31'h0, pio.pio_chipselect & ~pio.pio_write_n}, 32'h1);
    cfg_mask = 4'b0011;
    cfg_mask_wr = 1'b1;
    tick(1);
    cfg_mask_wr = 1'b0;
    tick(2);
    check_val("mk_count", {28'h0, evt_count}, 32'd1);
    tick(3);
    check_val("mk_wr_cnt", 32'(wlog.size()), 32'd2);
    if (wlog.size() > 1) begin
      check_val("mk_wr0_addr", {30'h0, wlog[0].a}, 32'h3);
      check_val("mk_wr1_addr", {30'h0, wlog[1].a}, 32'h2);
      check_val("mk_wr1_data", wlog[1].d, 32'h0000_0003);
    end
    check_val("mk_busy", {31'h0, busy}, 32'h0);
    wlog.delete();
    in_port = 4'b1010;
    tick(15);
    check_val("mk_irq_masked", {31'h0, pio.pio_irq}, 32'h0);
    check_val("mk_no_event", {28'h0, evt_count}, 32'd1);
    check_val("mk_no_wr", 32'(wlog.size()), 32'd0);
    pop_chk("mk_pop");
    check_val("mk_elapsed", 32'(cyc - p > 20), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_event_servicer.md
Name: pio_event_servicer

Overview:
- Avalon-MM master that services a 4-bit edge-capture PIO slave (s1 register map: 0 = data, 2 = irq mask, 3 = edge capture) without CPU involvement.
- On PIO irq it reads the edge-capture register, clears it, reads the live input level, and pushes a timestamped event record into a local FIFO for a downstream consumer.
- Also programs the PIO irq mask at reset exit and on request.
- Sits between the PIO slave port and the button/switch event consumer logic.

Parameters:
- DATA_W, 4, PIO input width; edge and level fields.
- FIFO_DEPTH, 8, event FIFO entries; power of 2, ≥2.
- TS_W, 16, timestamp counter width.
- MASK_INIT, 4'hF, irq mask written after reset.

Ports:
- clk  in  1  single clock domain.
- reset  in  1  asynchronous, active-high.
- pio_address  out  2  PIO register address.
- pio_chipselect  out  1  PIO chipselect; asserted only on writes.
- pio_write_n  out  1  PIO write strobe, active-low.
- pio_writedata  out  32  PIO write data.
- pio_readdata  in  32  PIO registered read data; 1-cycle latency from address.
- pio_irq  in  1  PIO interrupt, level.
- cfg_mask  in  DATA_W  new irq mask.
- cfg_mask_wr  in  1  one-cycle request to write cfg_mask.
- evt_valid  out  1  FIFO non-empty.
- evt_data  out  DATA_W*2+TS_W  head record: {edges, level, timestamp}, edges in the MSBs.
- evt_pop  in  1  consume head; ignored when empty.
- evt_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: pio_address=0, pio_chipselect=0, pio_write_n=1, pio_writedata=0, evt_valid=0, evt_count=0, busy=1. FSM enters MASK_WR; timestamp counter=0; pending-mask flag=0.
- Reset asserted mid-transaction: FIFO is flushed, FSM returns to MASK_WR. No partial event is pushed.
- Timestamp counter increments every clk and wraps modulo 2^TS_W.
- All PIO outputs are registered.

FSM states:
- MASK_WR:
  - Drives address=2, chipselect=1, write_n=0, writedata=zero-extended mask for one cycle.
  - Mask value is MASK_INIT after reset, else the pending cfg_mask. Clears the pending flag.
  - Next state: IDLE.
- IDLE:
  - Drives address=3, chipselect=0, write_n=1.
  - Priority 1: pending flag → MASK_WR.
  - Priority 2: pio_irq=1 and FIFO not full → RD_EDGE.
  - Otherwise stay in IDLE.
- RD_EDGE: holds address=3; latches the timestamp. Next state: CLR_EDGE.
- CLR_EDGE:
  - Samples pio_readdata[DATA_W-1:0] into edge_reg.
  - Drives address=3, chipselect=1, write_n=0, writedata=all-ones.
  - Next state: RD_LVL.
- RD_LVL: drives address=0. Next state: PUSH.
- PUSH:
  - Samples pio_readdata into level_reg.
  - If edge_reg≠0, writes {edge_reg, level_reg, ts} into the FIFO; otherwise drops the record.
  - Next state: IDLE.

Timing and boundary conditions:
- Latency: irq seen in IDLE at cycle N gives evt_valid/count update at N+5. PIO irq falls by N+3, so IDLE at N+5 does not re-trigger.
- cfg_mask_wr in any state: sets the pending flag and captures cfg_mask; last request wins. It is serviced at the next IDLE, ahead of irq service.
- FIFO full: no service starts. Edges keep accumulating (OR) in the PIO. No loss, no overflow flag; service resumes once a pop frees an entry.
- Known window: an edge arriving during RD_EDGE/CLR_EDGE is cleared by the PIO write and not reported. This is accepted and documented.
- Simultaneous push and pop: count unchanged, data order preserved.
- Pop when empty: ignored.
- Read/write pointers wrap modulo FIFO_DEPTH.
- evt_data is the registered head, valid whenever evt_valid=1.

Decomposition:
- Package pio_event_pkg holds:
  - state enum {MASK_WR, IDLE, RD_EDGE, CLR_EDGE, RD_LVL, PUSH};
  - PIO address constants ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3;
  - event record field offsets.
- One sub-module, pio_event_fifo: synchronous FIFO, parameterised width/depth, with push/pop/full/empty/count.

Test Plan:
- Reset release with a PIO model attached → exactly one write, address=2, writedata=0x0000000F, then busy=0 with address=3.
- Rising edge on in_port bit 2 (in_port 0→4) at PIO → one event: edges=4'b0100, level=4'b0100, timestamp equal to counter value in RD_EDGE. PIO irq low by N+3, evt_valid at N+5.
- Fill FIFO with 8 events (no pops), then toggle bit 0 → no PIO access while full. Pop once → next event reports edges=4'b0001; evt_count goes 8→7→8.
- Assert cfg_mask_wr with cfg_mask=4'b0011 during CLR_EDGE → event completes first, then a mask write with writedata=0x3; edges on bit 3 thereafter raise no irq and no events.
- Same-cycle push and pop with count=3 → count stays 3; popped records match push order.
- Assert reset during RD_LVL with count=2 → count=0, evt_valid=0, FSM replays MASK_WR with MASK_INIT.
